// File: rtl/alien_wave_controller.sv
// rtl/alien_wave_controller.sv - alien formation wave sequencer: move enable, speed, restart pulse, clear/invasion detect
module alien_wave_controller #(
    parameter int NUM_ALIENS    = 32,
    parameter int BASE_SPEED    = 32,
    parameter int KILL_STEP     = 4,
    parameter int WAVE_STEP     = 16,
    parameter int MAX_SPEED     = 320,
    parameter int INVASION_Y    = 400,
    parameter int FREEZE_FRAMES = 15,
    parameter int CLEAR_FRAMES  = 60,
    parameter int MAX_WAVE      = 15
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startGame,
    input  logic               alienHit,
    input  logic               playerHit,
    input  logic signed [10:0] lowestAlienY,
    output logic               moveEnable,
    output logic [9:0]         speed,
    output logic               movementResetN,
    output logic [5:0]         aliensAlive,
    output logic [3:0]         waveNum,
    output logic               waveCleared,
    output logic               gameOver
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REARM,
        S_RUN,
        S_FREEZE,
        S_CLEAR,
        S_OVER
    } state_t;

    localparam logic signed [10:0] INV_Y     = 11'(INVASION_Y);
    localparam logic [5:0]         ALIENS_N  = 6'(NUM_ALIENS);
    localparam logic [3:0]         WAVE_MAX  = 4'(MAX_WAVE);
    localparam logic [7:0]         FREEZE_N  = 8'(FREEZE_FRAMES);
    localparam logic [7:0]         CLEAR_N   = 8'(CLEAR_FRAMES);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_move_en;
    logic       r_mv_rstn;
    logic       r_wave_clr;
    logic       r_game_over;
    logic [5:0] r_alive;
    logic [3:0] r_wave;
    logic [9:0] r_speed;

    logic [7:0]  w_cnt_inc;
    logic [5:0]  w_alive_dec;
    logic        w_last_kill;
    logic        w_invasion;
    logic [15:0] w_speed_sum;
    logic [9:0]  w_speed_next;

    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_alive_dec = (r_alive != 6'd0) ? (r_alive - 6'd1) : 6'd0;
    assign w_last_kill = alienHit && (r_alive == 6'd1);
    assign w_invasion  = (lowestAlienY >= INV_Y);

    // Wide sum so the kill and wave terms cannot wrap before saturation.
    assign w_speed_sum  = 16'(BASE_SPEED)
                        + 16'(KILL_STEP) * (16'(NUM_ALIENS) - {10'd0, r_alive})
                        + 16'(WAVE_STEP) * ({12'd0, r_wave} - 16'd1);
    assign w_speed_next = (w_speed_sum > 16'(MAX_SPEED)) ? 10'(MAX_SPEED) : w_speed_sum[9:0];

    // Game sequencer: state, frame counter, alien/wave bookkeeping and registered controls.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_move_en   <= 1'b0;
            r_mv_rstn   <= 1'b1;
            r_wave_clr  <= 1'b0;
            r_game_over <= 1'b0;
            r_alive     <= ALIENS_N;
            r_wave      <= 4'd1;
        end else begin
            r_wave_clr <= 1'b0;
            r_mv_rstn  <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_move_en <= 1'b0;
                    if (startGame) begin
                        r_state   <= S_REARM;
                        r_cnt     <= 8'd0;
                        r_alive   <= ALIENS_N;
                        r_wave    <= 4'd1;
                        r_mv_rstn <= 1'b0;
                    end
                end
                S_REARM: begin
                    r_state   <= S_RUN;
                    r_cnt     <= 8'd0;
                    r_move_en <= 1'b1;
                    if (alienHit) r_alive <= w_alive_dec;
                end
                S_RUN: begin
                    if (alienHit) r_alive <= w_alive_dec;
                    // Invasion outranks the last kill, which outranks a player hit.
                    if (w_invasion) begin
                        r_state     <= S_OVER;
                        r_cnt       <= 8'd0;
                        r_move_en   <= 1'b0;
                        r_game_over <= 1'b1;
                    end else if (w_last_kill) begin
                        r_state    <= S_CLEAR;
                        r_cnt      <= 8'd0;
                        r_move_en  <= 1'b0;
                        r_wave_clr <= 1'b1;
                    end else if (playerHit) begin
                        r_state   <= S_FREEZE;
                        r_cnt     <= 8'd0;
                        r_move_en <= 1'b0;
                    end
                end
                S_FREEZE: begin
                    if (alienHit) r_alive <= w_alive_dec;
                    if (w_last_kill) begin
                        r_state    <= S_CLEAR;
                        r_cnt      <= 8'd0;
                        r_wave_clr <= 1'b1;
                    end else if (playerHit) begin
                        r_cnt <= 8'd0;
                    end else if (startOfFrame) begin
                        if (w_cnt_inc == FREEZE_N) begin
                            r_state   <= S_RUN;
                            r_cnt     <= 8'd0;
                            r_move_en <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_CLEAR: begin
                    if (startOfFrame) begin
                        if (w_cnt_inc == CLEAR_N) begin
                            r_state   <= S_REARM;
                            r_cnt     <= 8'd0;
                            r_alive   <= ALIENS_N;
                            r_wave    <= (r_wave == WAVE_MAX) ? r_wave : (r_wave + 4'd1);
                            r_mv_rstn <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_OVER: begin
                    r_move_en <= 1'b0;
                    if (startGame) begin
                        r_state     <= S_REARM;
                        r_cnt       <= 8'd0;
                        r_game_over <= 1'b0;
                        r_alive     <= ALIENS_N;
                        r_wave      <= 4'd1;
                        r_mv_rstn   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Speed tracks the formula only while rearming or running; frozen otherwise.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_speed <= 10'(BASE_SPEED);
        end else if (r_state == S_RUN || r_state == S_REARM) begin
            r_speed <= w_speed_next;
        end
    end

    assign moveEnable     = r_move_en;
    assign speed          = r_speed;
    assign movementResetN = r_mv_rstn;
    assign aliensAlive    = r_alive;
    assign waveNum        = r_wave;
    assign waveCleared    = r_wave_clr;
    assign gameOver       = r_game_over;

endmodule
